apb_master_bridge: RTL and testbench

- Upstream neighbour of the APB slave interface block.
- Converts a simple valid/ready request/response handshake from the control logic into legal two-phase APB transfers (SETUP, then ACCESS).
- Drives the master side of apb_if toward the slave interface and returns read data or error status to the requester.

---
 rtl/apb_master_bridge_pkg.sv | 13 +
 rtl/apb_master_bridge_if.sv | 28 ++
 rtl/apb_master_bridge_wait_timer.sv | 30 +++
 rtl/apb_master_bridge.sv | 135 +++++++++++++
 tb/tb_apb_master_bridge.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_master_bridge_pkg.sv
// Shared types and default widths for the APB master bridge.
package apb_master_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// APB bus between the master bridge and the slave interface block.
interface apb_if
    import apb_master_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic [ADDR_W-1:0] PADDR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_master_bridge_wait_timer.sv
// ACCESS-phase wait counter with limit compare.
// Only instantiated when APB_TIMEOUT_EN is defined.
module apb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic pclk,
    input  logic n_rst,
    input  logic in_access,
    input  logic pready,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;

    // Count stalled ACCESS cycles; any other state clears it so each ACCESS starts at zero.
    always_ff @(posedge pclk or negedge n_rst) begin
        if (!n_rst) begin
            wait_cnt <= '0;
        end else if (!in_access) begin
            wait_cnt <= '0;
        end else if (!pready) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    assign expired = in_access && !pready && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// APB master bridge: turns a valid/ready request into a SETUP/ACCESS APB transfer
// and returns a one-cycle response pulse with read data and error status.
// Optional feature: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES stalled cycles.
module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              n_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    apb_if.master             apb
);

    apb_state_t        state;
    apb_state_t        next_state;
    logic              psel;
    logic              penable;
    logic              complete;
    logic              abort;
    logic              accept;
    logic              timeout_hit;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              pwrite_q;

`ifdef APB_TIMEOUT_EN
    apb_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .pclk      (pclk),
        .n_rst     (n_rst),
        .in_access (state == ACCESS),
        .pready    (apb.PREADY),
        .expired   (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    assign accept = req_valid && req_ready;

    // State register; reset drops any APB cycle in flight because PSEL/PENABLE decode from state.
    always_ff @(posedge pclk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and APB phase decode; the completion cycle doubles as an accept slot.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        psel       = 1'b0;
        penable    = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    next_state = SETUP;
                end
            end
            SETUP: begin
                psel       = 1'b1;
                next_state = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (apb.PREADY) begin
                    complete   = 1'b1;
                    req_ready  = 1'b1;
                    next_state = req_valid ? SETUP : IDLE;
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Capture the request onto the APB address/data/direction; held until the next accept.
    always_ff @(posedge pclk or negedge n_rst) begin
        if (!n_rst) begin
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
        end else if (accept) begin
            paddr_q  <= req_addr;
            pwdata_q <= req_wdata;
            pwrite_q <= req_write;
        end
    end

    // Response registers: one-cycle valid pulse, data and error held until the next completion.
    always_ff @(posedge pclk or negedge n_rst) begin
        if (!n_rst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= complete || abort;
            if (complete) begin
                rsp_err   <= apb.PSLVERR;
                rsp_rdata <= pwrite_q ? '0 : apb.PRDATA;
            end else if (abort) begin
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end
        end
    end

    assign apb.PSEL    = psel;
    assign apb.PENABLE = penable;
    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = pwdata_q;
    assign apb.PWRITE  = pwrite_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed, table-driven testbench for apb_master_bridge.
// With APB_TIMEOUT_EN defined the long-stall test expects an abort instead of a completion.
module tb_apb_master_bridge;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic        tb_clk;
    logic        tb_rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int check_cnt;
    int pass_cnt;

    vec_t vecs [6];

    apb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master_bridge #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .pclk      (tb_clk),
        .n_rst     (tb_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .apb       (bus.master)
    );

    // Free-running 100 MHz clock.
    initial begin
        tb_clk = 1'b0;
        forever #5 tb_clk = ~tb_clk;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge tb_clk);
        #1;
    endtask

    // One complete transfer from IDLE, checking every phase and the response pulse.
    task automatic applyStimulus(input vec_t v);
        checkOutput("idle_req_ready", 32'(req_ready), 32'd1);
        req_valid     = 1'b1;
        req_write     = v.wr;
        req_addr      = v.addr;
        req_wdata     = v.wdata;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b1;
        bus.PRDATA    = 32'hBAD0_0BAD;
        nextCycle();
        req_valid = 1'b0;
        req_write = ~v.wr;
        req_addr  = ~v.addr;
        req_wdata = ~v.wdata;
        checkOutput("setup_psel", 32'(bus.PSEL), 32'd1);
        checkOutput("setup_penable", 32'(bus.PENABLE), 32'd0);
        checkOutput("setup_req_ready", 32'(req_ready), 32'd0);
        checkOutput("setup_paddr", bus.PADDR, v.addr);
        checkOutput("setup_pwrite", 32'(bus.PWRITE), 32'(v.wr));
        if (v.wr) begin
            checkOutput("setup_pwdata", bus.PWDATA, v.wdata);
        end
        for (int w = 0; w <= v.waits; w++) begin
            nextCycle();
            checkOutput("access_psel", 32'(bus.PSEL), 32'd1);
            checkOutput("access_penable", 32'(bus.PENABLE), 32'd1);
            checkOutput("access_paddr", bus.PADDR, v.addr);
            checkOutput("access_pwrite", 32'(bus.PWRITE), 32'(v.wr));
            if (v.wr) begin
                checkOutput("access_pwdata", bus.PWDATA, v.wdata);
            end
            if (w == v.waits) begin
                bus.PREADY  = 1'b1;
                bus.PSLVERR = v.slverr;
                bus.PRDATA  = v.prdata;
                #1;
                checkOutput("access_done_req_ready", 32'(req_ready), 32'd1);
            end else begin
                bus.PREADY  = 1'b0;
                bus.PSLVERR = 1'b1;
                bus.PRDATA  = ~v.prdata;
                #1;
                checkOutput("access_wait_req_ready", 32'(req_ready), 32'd0);
                checkOutput("access_wait_no_rsp", 32'(rsp_valid), 32'd0);
            end
        end
        nextCycle();
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        checkOutput("rsp_valid_pulse", 32'(rsp_valid), 32'd1);
        checkOutput("rsp_err", 32'(rsp_err), 32'(v.exp_err));
        checkOutput("rsp_rdata", rsp_rdata, v.exp_rdata);
        checkOutput("post_psel", 32'(bus.PSEL), 32'd0);
        nextCycle();
        checkOutput("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        checkOutput("rsp_rdata_hold", rsp_rdata, v.exp_rdata);
        checkOutput("rsp_err_hold", 32'(rsp_err), 32'(v.exp_err));
    endtask

    initial begin
        vec_t lw;
        logic [31:0] b2b_addr [4];
        int pulses;

        check_cnt = 0;
        pass_cnt  = 0;

        //            wr    addr          wdata         waits prdata        slverr exp_rdata     exp_err
        vecs[0] = '{1'b1, 32'h0000_0004, 32'h8000_0000, 0, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 3, 32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 1, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1};
        vecs[3] = '{1'b1, 32'h0000_0024, 32'h0000_5A5A, 0, 32'hCAFE_F00D, 1'b0, 32'h0000_0000, 1'b0};
        vecs[4] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 2, 32'h0BAD_CAFE, 1'b1, 32'h0000_0000, 1'b1};
        vecs[5] = '{1'b0, 32'h0000_0100, 32'h0000_0000, 0, 32'hA5A5_0001, 1'b0, 32'hA5A5_0001, 1'b0};

        tb_rst_n    = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        bus.PRDATA  = '0;

        repeat (3) nextCycle();
        checkOutput("reset_psel", 32'(bus.PSEL), 32'd0);
        checkOutput("reset_penable", 32'(bus.PENABLE), 32'd0);
        checkOutput("reset_pwrite", 32'(bus.PWRITE), 32'd0);
        checkOutput("reset_paddr", bus.PADDR, 32'd0);
        checkOutput("reset_pwdata", bus.PWDATA, 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
        tb_rst_n = 1'b1;
        nextCycle();
        checkOutput("post_reset_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            $display("[TB] vector %0d", i);
            applyStimulus(vecs[i]);
        end

`ifdef APB_TIMEOUT_EN
        // Stall forever: 16 ACCESS cycles, then abort with an error response.
        $display("[TB] timeout abort");
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0080;
        nextCycle();
        req_valid   = 1'b0;
        bus.PREADY  = 1'b0;
        bus.PRDATA  = 32'h5555_AAAA;
        bus.PSLVERR = 1'b0;
        checkOutput("to_setup_psel", 32'(bus.PSEL), 32'd1);
        for (int k = 0; k < 16; k++) begin
            nextCycle();
            checkOutput("to_access_penable", 32'(bus.PENABLE), 32'd1);
            checkOutput("to_access_no_rsp", 32'(rsp_valid), 32'd0);
        end
        nextCycle();
        checkOutput("to_psel", 32'(bus.PSEL), 32'd0);
        checkOutput("to_penable", 32'(bus.PENABLE), 32'd0);
        checkOutput("to_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("to_rsp_err", 32'(rsp_err), 32'd1);
        checkOutput("to_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("to_req_ready", 32'(req_ready), 32'd1);
        nextCycle();
        checkOutput("to_rsp_valid_drop", 32'(rsp_valid), 32'd0);
`else
        // Without the timer a long stall simply completes normally.
        $display("[TB] long stall");
        lw = '{1'b0, 32'h0000_0080, 32'h0, 20, 32'h5555_AAAA, 1'b0, 32'h5555_AAAA, 1'b0};
        applyStimulus(lw);
`endif

        // Back-to-back: four writes with req_valid held, zero wait states, 8 busy cycles.
        $display("[TB] back-to-back");
        b2b_addr[0] = 32'h0000_1000;
        b2b_addr[1] = 32'h0000_1004;
        b2b_addr[2] = 32'h0000_1008;
        b2b_addr[3] = 32'h0000_100C;
        pulses      = 0;
        bus.PREADY  = 1'b1;
        bus.PSLVERR = 1'b0;
        req_valid   = 1'b1;
        req_write   = 1'b1;
        req_addr    = b2b_addr[0];
        req_wdata   = 32'h0000_0000;
        for (int i = 0; i < 8; i++) begin
            nextCycle();
            if (rsp_valid) pulses++;
            checkOutput("b2b_psel", 32'(bus.PSEL), 32'd1);
            checkOutput("b2b_penable", 32'(bus.PENABLE), 32'(i % 2));
            checkOutput("b2b_paddr", bus.PADDR, b2b_addr[i / 2]);
            checkOutput("b2b_pwdata", bus.PWDATA, 32'(i / 2));
            if (i % 2 == 0) begin
                if (i / 2 + 1 < 4) begin
                    req_addr  = b2b_addr[i / 2 + 1];
                    req_wdata = 32'(i / 2 + 1);
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        nextCycle();
        if (rsp_valid) pulses++;
        bus.PREADY = 1'b0;
        checkOutput("b2b_end_psel", 32'(bus.PSEL), 32'd0);
        checkOutput("b2b_rsp_pulses", 32'(pulses), 32'd4);
        checkOutput("b2b_rsp_rdata", rsp_rdata, 32'd0);
        nextCycle();
        checkOutput("b2b_rsp_drop", 32'(rsp_valid), 32'd0);

        // Reset in the middle of a stalled ACCESS phase.
        $display("[TB] reset mid-transfer");
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0040;
        nextCycle();
        req_valid = 1'b0;
        nextCycle();
        checkOutput("mid_access_penable", 32'(bus.PENABLE), 32'd1);
        nextCycle();
        tb_rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_psel", 32'(bus.PSEL), 32'd0);
        checkOutput("mid_reset_penable", 32'(bus.PENABLE), 32'd0);
        checkOutput("mid_reset_paddr", bus.PADDR, 32'd0);
        bus.PREADY = 1'b1;
        repeat (3) nextCycle();
        tb_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkOutput("post_mid_reset_no_rsp", 32'(rsp_valid), 32'd0);
            checkOutput("post_mid_reset_req_ready", 32'(req_ready), 32'd1);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
